// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
//   Read-side controller for the 8-entry register-file FIFO. Owns the head and
//   tail pointers plus occupancy, drives the write address and gated write
//   enable into the write decoder, and captures the head entry of the
//   flattened register file into a registered dout on every accepted read.
//
// Ports
//   clk_i         system clock, rising edge
//   reset_n_i     asynchronous active-low reset
//   re_i          read request
//   we_i          write request
//   rf_data_i     register-file contents, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_addr_o     tail pointer, to write decoder address
//   wr_en_o       we & ~full, to write decoder enable
//   rd_addr_o     head pointer
//   dout_o        registered read data
//   data_count_o  occupancy 0..8
//   empty_o       FIFO empty
//   full_o        FIFO full
//   rd_ack_o      1-cycle pulse: read accepted, dout updated this edge
//   rd_err_o      1-cycle pulse: read refused (empty)
//   wr_err_o      1-cycle pulse: write refused (full)
//
// State table
//   state    | meaning
//   ---------+-----------------------------
//   ST_EMPTY | occupancy 0, reads refused
//   ST_PART  | occupancy 1..7
//   ST_FULL  | occupancy 8, writes refused
// ---------------------------------------------------------------------------
module fifo_read_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    re_i,
   input  logic                    we_i,
   input  logic [8*DATA_WIDTH-1:0] rf_data_i,
   output logic [2:0]              wr_addr_o,
   output logic                    wr_en_o,
   output logic [2:0]              rd_addr_o,
   output logic [DATA_WIDTH-1:0]   dout_o,
   output logic [3:0]              data_count_o,
   output logic                    empty_o,
   output logic                    full_o,
   output logic                    rd_ack_o,
   output logic                    rd_err_o,
   output logic                    wr_err_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_PART  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              head_q, head_d;
   logic [2:0]              tail_q, tail_d;
   logic [3:0]              count_q, count_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                    rd_ack_q, rd_err_q, wr_err_q;

   logic                    empty, full;
   logic                    wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0]   entry [8];
   logic [DATA_WIDTH-1:0]   head_data;

   for (genvar gi = 0; gi < 8; gi++) begin : g_entry
      assign entry[gi] = rf_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   assign head_data = entry[head_q];

   // ---------------- state register ----------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (wr_acc) state_d = ST_PART;
         ST_PART: begin
            if (wr_acc && !rd_acc && count_q == 4'd7)
               state_d = ST_FULL;
            else if (rd_acc && !wr_acc && count_q == 4'd1)
               state_d = ST_EMPTY;
         end
         ST_FULL:  if (rd_acc) state_d = ST_PART;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // ---------------- output / decode logic ----------------
   // Flags come from the state, so a refused write is blocked by a registered
   // signal and never reaches the decoder.
   always_comb begin
      empty   = (state_q == ST_EMPTY);
      full    = (state_q == ST_FULL);
      wr_acc  = we_i & ~full;
      rd_acc  = re_i & ~empty;
      wr_en_o = wr_acc;
   end

   // ---------------- datapath ----------------
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      dout_d  = dout_q;
      count_d = count_q;
      if (rd_acc) begin
         head_d = head_q + 3'd1;
         dout_d = head_data;
      end
      if (wr_acc) begin
         tail_d = tail_q + 3'd1;
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         head_q   <= 3'd0;
         tail_q   <= 3'd0;
         count_q  <= 4'd0;
         dout_q   <= '0;
         rd_ack_q <= 1'b0;
         rd_err_q <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         rd_ack_q <= rd_acc;
         rd_err_q <= re_i & empty;
         wr_err_q <= we_i & full;
      end
   end

   assign wr_addr_o    = tail_q;
   assign rd_addr_o    = head_q;
   assign dout_o       = dout_q;
   assign data_count_o = count_q;
   assign empty_o      = empty;
   assign full_o       = full;
   assign rd_ack_o     = rd_ack_q;
   assign rd_err_o     = rd_err_q;
   assign wr_err_o     = wr_err_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_ctrl
//   Directed bench for fifo_read_ctrl. The bench plays the register file and
//   write decoder; written values go into a scoreboard queue and are popped
//   when a read is expected to be accepted.
// ---------------------------------------------------------------------------
module tb_fifo_read_ctrl;

   localparam int DW = 32;

   logic            clk;
   logic            reset_n;
   logic            re, we;
   logic [8*DW-1:0] rf_data;
   logic [2:0]      wr_addr, rd_addr;
   logic            wr_en;
   logic [DW-1:0]   dout;
   logic [3:0]      data_count;
   logic            empty, full, rd_ack, rd_err, wr_err;

   logic [DW-1:0]   mem [8];
   logic [DW-1:0]   wdata;

   int              errors = 0;
   int              checks = 0;

   logic [DW-1:0]   sb [$];
   int              m_count;
   logic [2:0]      m_head, m_tail;
   logic [DW-1:0]   m_dout;
   logic [DW-1:0]   next_val;

   fifo_read_ctrl #(.DATA_WIDTH(DW)) dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .re_i         (re),
      .we_i         (we),
      .rf_data_i    (rf_data),
      .wr_addr_o    (wr_addr),
      .wr_en_o      (wr_en),
      .rd_addr_o    (rd_addr),
      .dout_o       (dout),
      .data_count_o (data_count),
      .empty_o      (empty),
      .full_o       (full),
      .rd_ack_o     (rd_ack),
      .rd_err_o     (rd_err),
      .wr_err_o     (wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
   end

   always @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wdata;
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_flat
      assign rf_data[gi*DW +: DW] = mem[gi];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input logic e_ack, input logic e_rerr, input logic e_werr);
      chk("rd_ack", {31'd0, rd_ack}, {31'd0, e_ack});
      chk("rd_err", {31'd0, rd_err}, {31'd0, e_rerr});
      chk("wr_err", {31'd0, wr_err}, {31'd0, e_werr});
      chk("count", {28'd0, data_count}, m_count[DW-1:0]);
      chk("empty", {31'd0, empty}, {31'd0, (m_count == 0)});
      chk("full", {31'd0, full}, {31'd0, (m_count == 8)});
      chk("wr_addr", {29'd0, wr_addr}, {29'd0, m_tail});
      chk("rd_addr", {29'd0, rd_addr}, {29'd0, m_head});
      chk("dout", dout, m_dout);
   endtask

   // One clock of stimulus: drive {we,re} just after an edge, check the
   // combinational enable, then check registered results after the next edge.
   task automatic op(input logic w, input logic r);
      logic wacc, racc;
      we    = w;
      re    = r;
      wdata = next_val;
      wacc  = w && (m_count != 8);
      racc  = r && (m_count != 0);
      #1;
      chk("wr_en", {31'd0, wr_en}, {31'd0, wacc});
      if (racc) begin
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed=0 expected=entry");
         end else begin
            m_dout = sb.pop_front();
         end
         m_head = m_head + 3'd1;
      end
      if (wacc) begin
         sb.push_back(next_val);
         m_tail   = m_tail + 3'd1;
         next_val = next_val + 1;
      end
      m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
      @(posedge clk);
      #1;
      chk_regs(racc, r && !racc, w && !wacc);
   endtask

   task automatic model_reset();
      sb.delete();
      m_count = 0;
      m_head  = 3'd0;
      m_tail  = 3'd0;
      m_dout  = '0;
   endtask

   initial begin
      reset_n  = 1'b0;
      we       = 1'b0;
      re       = 1'b0;
      wdata    = '0;
      next_val = 32'd1;
      model_reset();
      @(posedge clk);
      #1;
      chk_regs(1'b0, 1'b0, 1'b0);
      chk("wr_en_rst", {31'd0, wr_en}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk_regs(1'b0, 1'b0, 1'b0);

      // fill: data 1..8 at addresses 0..7, then a refused 9th write
      for (int i = 0; i < 8; i++) op(1'b1, 1'b0);
      op(1'b1, 1'b0);

      // drain: dout 1..8, then a refused read leaves dout at 8
      for (int i = 0; i < 8; i++) op(1'b0, 1'b1);
      op(1'b0, 1'b1);
      chk("dout_after_drain", dout, 32'd8);

      // wrap: 5 writes, 5 reads, 6 writes -> tail wraps, head=5, count=6
      for (int i = 0; i < 5; i++) op(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) op(1'b0, 1'b1);
      for (int i = 0; i < 6; i++) op(1'b1, 1'b0);
      chk("wrap_head", {29'd0, rd_addr}, 32'd5);
      chk("wrap_tail", {29'd0, wr_addr}, 32'd3);
      chk("wrap_count", {28'd0, data_count}, 32'd6);

      // simultaneous at count 4
      op(1'b0, 1'b1);
      op(1'b0, 1'b1);
      op(1'b1, 1'b1);
      op(1'b1, 1'b1);
      op(1'b0, 1'b0);

      // drain, simultaneous at count 0
      for (int i = 0; i < 4; i++) op(1'b0, 1'b1);
      op(1'b1, 1'b1);

      // fill, simultaneous at count 8
      for (int i = 0; i < 7; i++) op(1'b1, 1'b0);
      op(1'b1, 1'b1);
      op(1'b1, 1'b0);
      op(1'b0, 1'b1);
      op(1'b1, 1'b1);

      // mid-run reset with a write in flight
      we      = 1'b1;
      re      = 1'b1;
      wdata   = next_val;
      #1;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk_regs(1'b0, 1'b0, 1'b0);
      chk("wr_en_midrst", {31'd0, wr_en}, 32'd1);
      @(posedge clk);
      #1;
      chk_regs(1'b0, 1'b0, 1'b0);
      we      = 1'b0;
      re      = 1'b0;
      reset_n = 1'b1;

      // life after reset
      op(1'b1, 1'b0);
      op(1'b1, 1'b0);
      op(1'b0, 1'b1);
      op(1'b1, 1'b1);
      op(1'b0, 1'b1);
      op(1'b0, 1'b1);
      op(1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
